// File: rtl/rggen_bus_router_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rggen_rtl_pkg : shared status/direction types and router FSM states  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rggen_router_state;

endpackage
`default_nettype wire

// File: rtl/rggen_bus_router_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rggen_bus_router_if : host-side access bus between bridge and router |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface rggen_bus_router_if
  import rggen_rtl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 16
);
  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  rggen_direction            direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      done;
  logic                      read_done;
  logic                      write_done;
  logic [DATA_WIDTH-1:0]     read_data;
  rggen_status               status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, read_done, write_done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, read_done, write_done, read_data, status
  );
endinterface
`default_nettype wire

// File: rtl/rggen_or_reducer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rggen_or_reducer : AND-OR merge of N one-hot selected WIDTH-bit words |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module rggen_or_reducer #(
  parameter int WIDTH = 1,
  parameter int N     = 1
)(
  input  var logic [N-1:0]       i_select,
  input  var logic [N*WIDTH-1:0] i_data,
  output logic     [WIDTH-1:0]   o_data
);
  always_comb begin
    o_data = '0;
    for (int k = 0; k < N; k++) begin
      o_data = o_data | (i_data[k*WIDTH+:WIDTH] & {WIDTH{i_select[k]}});
    end
  end
endmodule
`default_nettype wire

// File: rtl/rggen_bus_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rggen_bus_router : broadcasts a host access to register slots and     |
// | merges their response, with timeout, multi-hit and unmapped handling  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module rggen_bus_router
  import rggen_rtl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 16,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter bit UNMAPPED_ERROR  = 1'b1
)(
  input  var logic                                clk,
  input  var logic                                rst_n,
  rggen_bus_router_if.slave                       bus_if,
  output logic [TOTAL_REGISTERS-1:0]              o_reg_request,
  output logic [ADDRESS_WIDTH-1:0]                o_reg_address,
  output logic                                    o_reg_direction,
  output logic [DATA_WIDTH-1:0]                   o_reg_write_data,
  output logic [DATA_WIDTH/8-1:0]                 o_reg_write_strobe,
  input  var logic [TOTAL_REGISTERS-1:0]          i_reg_select,
  input  var logic [TOTAL_REGISTERS-1:0]          i_reg_ready,
  input  var logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_reg_read_data,
  input  var logic [TOTAL_REGISTERS*2-1:0]        i_reg_status
);
  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST =
    COUNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  rggen_router_state       state_q, state_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    done_q, done_d;
  logic                    read_done_q, read_done_d;
  logic                    write_done_q, write_done_d;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;
  rggen_status             status_q, status_d;

  logic [DATA_WIDTH-1:0]   merged_data;
  logic [1:0]              merged_status;
  logic                    multi_hit, no_hit, slot_ready, timed_out;

  rggen_or_reducer #(.WIDTH(DATA_WIDTH), .N(TOTAL_REGISTERS)) u_data_merge (
    .i_select (i_reg_select),
    .i_data   (i_reg_read_data),
    .o_data   (merged_data)
  );

  rggen_or_reducer #(.WIDTH(2), .N(TOTAL_REGISTERS)) u_status_merge (
    .i_select (i_reg_select),
    .i_data   (i_reg_status),
    .o_data   (merged_status)
  );

  // Clearing the lowest set bit leaves a nonzero value only when two or more slots hit.
  assign multi_hit  = |(i_reg_select & (i_reg_select - 1'b1));
  assign no_hit     = ~|i_reg_select;
  assign slot_ready = |(i_reg_select & i_reg_ready);
  assign timed_out  = (TIMEOUT_CYCLES != 0) && (count_q == COUNT_LAST);

  assign o_reg_request      = {TOTAL_REGISTERS{bus_if.request && (state_q == WAIT)}};
  assign o_reg_address      = bus_if.address;
  assign o_reg_direction    = bus_if.direction;
  assign o_reg_write_data   = bus_if.write_data;
  assign o_reg_write_strobe = bus_if.write_strobe;

  assign bus_if.done       = done_q;
  assign bus_if.read_done  = read_done_q;
  assign bus_if.write_done = write_done_q;
  assign bus_if.read_data  = read_data_q;
  assign bus_if.status     = status_q;

  always_comb begin
    state_d      = state_q;
    count_d      = '0;
    done_d       = 1'b0;
    read_done_d  = 1'b0;
    write_done_d = 1'b0;
    read_data_d  = read_data_q;
    status_d     = status_q;
    case (state_q)
      IDLE: if (bus_if.request) state_d = WAIT;
      WAIT: begin
        if (!bus_if.request) begin
          state_d = IDLE;
        end else begin
          count_d = (count_q != COUNT_MAX) ? count_q + COUNT_WIDTH'(1) : count_q;
          if (multi_hit || no_hit || slot_ready || timed_out) begin
            state_d      = RESP;
            done_d       = 1'b1;
            read_done_d  = (bus_if.direction == RGGEN_READ);
            write_done_d = (bus_if.direction == RGGEN_WRITE);
            read_data_d  = '0;
            if (multi_hit) begin
              status_d = RGGEN_SLAVE_ERROR;
            end else if (no_hit) begin
              status_d = UNMAPPED_ERROR ? RGGEN_DECODE_ERROR : RGGEN_OKAY;
            end else if (slot_ready) begin
              status_d = rggen_status'(merged_status);
              if (bus_if.direction == RGGEN_READ) read_data_d = merged_data;
            end else begin
              status_d = RGGEN_SLAVE_ERROR;
            end
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      done_q       <= 1'b0;
      read_done_q  <= 1'b0;
      write_done_q <= 1'b0;
      read_data_q  <= '0;
      status_q     <= RGGEN_OKAY;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      done_q       <= done_d;
      read_done_q  <= read_done_d;
      write_done_q <= write_done_d;
      read_data_q  <= read_data_d;
      status_q     <= status_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rggen_bus_router.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rggen_bus_router : directed + random accesses against two routers  |
// | (unmapped -> error / unmapped -> okay) and a response model           |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_rggen_bus_router;
  import rggen_rtl_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rggen_bus_router_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus0 ();
  rggen_bus_router_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus1 ();

  logic [N-1:0]    reg_select, reg_ready;
  logic [N*DW-1:0] reg_read_data;
  logic [N*2-1:0]  reg_status;
  logic [N-1:0]    rreq0, rreq1;
  logic [AW-1:0]   raddr0, raddr1;
  logic            rdir0, rdir1;
  logic [DW-1:0]   rwd0, rwd1;
  logic [DW/8-1:0] rws0, rws1;

  rggen_bus_router #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TOTAL_REGISTERS(N),
                     .TIMEOUT_CYCLES(TO), .UNMAPPED_ERROR(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus_if(bus0.slave),
    .o_reg_request(rreq0), .o_reg_address(raddr0), .o_reg_direction(rdir0),
    .o_reg_write_data(rwd0), .o_reg_write_strobe(rws0),
    .i_reg_select(reg_select), .i_reg_ready(reg_ready),
    .i_reg_read_data(reg_read_data), .i_reg_status(reg_status)
  );

  rggen_bus_router #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TOTAL_REGISTERS(N),
                     .TIMEOUT_CYCLES(TO), .UNMAPPED_ERROR(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus_if(bus1.slave),
    .o_reg_request(rreq1), .o_reg_address(raddr1), .o_reg_direction(rdir1),
    .o_reg_write_data(rwd1), .o_reg_write_strobe(rws1),
    .i_reg_select(reg_select), .i_reg_ready(reg_ready),
    .i_reg_read_data(reg_read_data), .i_reg_status(reg_status)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_host(input logic req, input logic [AW-1:0] addr, input logic dir);
    logic [DW-1:0] wd;
    wd = $urandom;
    bus0.request = req;      bus1.request = req;
    bus0.address = addr;     bus1.address = addr;
    bus0.direction = rggen_direction'(dir);
    bus1.direction = rggen_direction'(dir);
    bus0.write_data = wd;    bus1.write_data = wd;
    bus0.write_strobe = 4'hF; bus1.write_strobe = 4'hF;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_done0"}, 64'(bus0.done), 64'd0);
    chk({tag, "_done1"}, 64'(bus1.done), 64'd0);
    chk({tag, "_rdata0"}, 64'(bus0.read_data), 64'd0);
    chk({tag, "_status0"}, 64'(bus0.status), 64'(RGGEN_OKAY));
    chk({tag, "_status1"}, 64'(bus1.status), 64'(RGGEN_OKAY));
    chk({tag, "_regreq0"}, 64'(rreq0), 64'd0);
  endtask

  // One access: slot side holds select, asserts ready on the selected slot d cycles into WAIT.
  task automatic run_access(input string tag, input logic dir, input logic [N-1:0] sel,
                            input int d, input logic [N-1:0] noise);
    int pop, k, lat, n;
    logic [1:0] st0, st1;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] addr;
    pop = $countones(sel);
    k = 0;
    for (int i = 0; i < N; i++) if (sel[i]) k = i;
    if (pop > 1) begin
      lat = 2; st0 = RGGEN_SLAVE_ERROR; st1 = RGGEN_SLAVE_ERROR; exp_data = '0;
    end else if (pop == 0) begin
      lat = 2; st0 = RGGEN_DECODE_ERROR; st1 = RGGEN_OKAY; exp_data = '0;
    end else if (d <= TO - 1) begin
      lat = 2 + d; st0 = reg_status[k*2+:2]; st1 = st0;
      exp_data = dir ? '0 : reg_read_data[k*DW+:DW];
    end else begin
      lat = TO + 1; st0 = RGGEN_SLAVE_ERROR; st1 = RGGEN_SLAVE_ERROR; exp_data = '0;
    end
    addr = AW'($urandom);
    @(negedge clk);
    set_host(1'b1, addr, dir);
    reg_select = sel;
    reg_ready = (pop == 1) ? (noise & ~sel) : noise;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      n = c;
      if (c == 1) begin
        chk({tag, "_wait_regreq"}, 64'(rreq0), 64'hF);
        chk({tag, "_wait_addr"}, 64'(raddr1), 64'(addr));
      end
      if (pop == 1 && c == 1 + d) reg_ready = reg_ready | sel;
      if (bus0.done || bus1.done) break;
    end
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_done0"}, 64'(bus0.done), 64'd1);
    chk({tag, "_done1"}, 64'(bus1.done), 64'd1);
    chk({tag, "_status0"}, 64'(bus0.status), 64'(st0));
    chk({tag, "_status1"}, 64'(bus1.status), 64'(st1));
    chk({tag, "_rdata0"}, 64'(bus0.read_data), 64'(exp_data));
    chk({tag, "_rdata1"}, 64'(bus1.read_data), 64'(exp_data));
    chk({tag, "_rdone0"}, 64'(bus0.read_done), 64'(!dir));
    chk({tag, "_wdone0"}, 64'(bus0.write_done), 64'(dir));
    chk({tag, "_resp_regreq0"}, 64'(rreq0), 64'd0);
    chk({tag, "_resp_regreq1"}, 64'(rreq1), 64'd0);
    bus0.request = 1'b0; bus1.request = 1'b0;
    reg_ready = '0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse0"}, 64'(bus0.done), 64'd0);
    chk({tag, "_pulse1"}, 64'(bus1.done), 64'd0);
  endtask

  initial begin
    logic [9:0] mask0, mask1;
    logic [N-1:0] sel;
    int i0;
    set_host(1'b0, '0, 1'b0);
    reg_select = '0; reg_ready = '0; reg_read_data = '0; reg_status = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Read slot 2 of 4, ready 3 cycles into WAIT
    reg_read_data = {32'h1111_1111, 32'hA5A5_0001, 32'h2222_2222, 32'h3333_3333};
    reg_status = {2'b10, 2'b00, 2'b11, 2'b10};
    run_access("read_slot2", 1'b0, 4'b0100, 3, 4'b1011);

    // Unmapped write
    run_access("unmapped_wr", 1'b1, 4'b0000, 0, 4'b1111);

    // Multi-hit with slot 0 ready
    run_access("multi_hit", 1'b0, 4'b0011, 0, 4'b0001);

    // Timeout, and ready arriving in the timeout cycle
    run_access("timeout", 1'b0, 4'b0010, 30, 4'b1101);
    reg_status = {2'b01, 2'b00, 2'b00, 2'b00};
    reg_read_data[3*DW+:DW] = 32'hCAFE_F00D;
    run_access("ready_at_timeout", 1'b0, 4'b1000, TO - 1, 4'b0000);

    // Reset pulsed during WAIT
    @(negedge clk);
    set_host(1'b1, 16'h0040, 1'b0);
    reg_select = 4'b0001; reg_ready = '0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset_hold");
    bus0.request = 1'b0; bus1.request = 1'b0;
    rst_n = 1'b1;
    reg_status = $urandom;
    run_access("after_reset", 1'b0, 4'b0001, 1, 4'b0110);

    // Request held across three back-to-back reads
    @(negedge clk);
    set_host(1'b1, 16'h0008, 1'b0);
    reg_select = 4'b0100; reg_ready = 4'b0100;
    reg_read_data[2*DW+:DW] = 32'h0BAD_BEEF;
    reg_status[2*2+:2] = 2'b00;
    mask0 = '0; mask1 = '0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      mask0[c] = bus0.done;
      mask1[c] = bus1.done;
      if (bus0.done) begin
        chk("b2b_regreq", 64'(rreq0), 64'd0);
        chk("b2b_rdata", 64'(bus0.read_data), 64'h0BAD_BEEF);
      end
      if (c == 8) begin bus0.request = 1'b0; bus1.request = 1'b0; end
    end
    chk("b2b_pulses0", 64'(mask0), 64'h124);
    chk("b2b_pulses1", 64'(mask1), 64'h124);
    reg_ready = '0;

    // Randomized accesses
    for (int t = 0; t < 40; t++) begin
      int r;
      r = $urandom_range(0, 9);
      i0 = $urandom_range(0, N - 1);
      if (r < 6) sel = N'(1 << i0);
      else if (r < 8) sel = '0;
      else sel = N'((1 << i0) | (1 << ((i0 + 1 + $urandom_range(0, 2)) % N)));
      reg_read_data = {$urandom, $urandom, $urandom, $urandom};
      reg_status = 8'($urandom);
      run_access("random", 1'($urandom), sel, $urandom_range(0, 11), N'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
